// File: rtl/mips_pkg.sv
// Shared opcode/funct encodings, ALU operation codes and the control bundle
// passed from the decode logic into the ID/EX register.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4,
    ALU_LUI = 3'd5
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    alu_src;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{alu_op: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/id_control_decoder.sv
// Combinational instruction decoder: control bundle, destination select,
// immediate extension, legality and whether the instruction reads rt.
module id_control_decoder
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic [31:0]       instr,
  output ctrl_t             ctrl,
  output logic [ADDR_W-1:0] dest,
  output logic [DATA_W-1:0] imm,
  output logic              legal,
  output logic              reads_rt
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_rs;

  assign opcode    = instr[31:26];
  assign funct     = instr[5:0];
  assign unused_rs = &{1'b0, instr[25:21]};

  always_comb begin
    ctrl     = CTRL_NOP;
    legal    = 1'b1;
    reads_rt = 1'b0;
    dest     = instr[20:16];
    imm      = {{(DATA_W-16){instr[15]}}, instr[15:0]};
    case (opcode)
      OP_RTYPE: begin
        dest           = instr[15:11];
        reads_rt       = 1'b1;
        ctrl.reg_write = 1'b1;
        case (funct)
          FN_ADD:  ctrl.alu_op = ALU_ADD;
          FN_SUB:  ctrl.alu_op = ALU_SUB;
          FN_AND:  ctrl.alu_op = ALU_AND;
          FN_OR:   ctrl.alu_op = ALU_OR;
          FN_SLT:  ctrl.alu_op = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND : ALU_OR;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        imm            = {{(DATA_W-16){1'b0}}, instr[15:0]};
      end
      OP_LUI: begin
        ctrl.alu_op    = ALU_LUI;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        reads_rt       = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_op = ALU_SUB;
        ctrl.branch = 1'b1;
        reads_rt    = 1'b1;
      end
      default: legal = 1'b0;
    endcase

    // Writes to $0 are architecturally discarded, so never request them.
    if (dest == '0)
      ctrl.reg_write = 1'b0;

    if (!legal) begin
      ctrl     = CTRL_NOP;
      reads_rt = 1'b0;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// Decode stage plus ID/EX pipeline register with load-use stall and EX flush.
// Define WB_BYPASS_EN to forward the WB write port into the captured operands.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              validIn,
  input  logic [31:0]       instrIn,
  input  logic [31:0]       pcIn,
  input  logic              flush,
  output logic [ADDR_W-1:0] readRegister1,
  output logic [ADDR_W-1:0] readRegister2,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [ADDR_W-1:0] writeRegister,
  input  logic [DATA_W-1:0] writeBack,
  input  logic              RegisterWrite,
  output logic              stallOut,
  output logic              exValid,
  output logic [DATA_W-1:0] exPc,
  output logic [DATA_W-1:0] exRsData,
  output logic [DATA_W-1:0] exRtData,
  output logic [DATA_W-1:0] exImm,
  output logic [ADDR_W-1:0] exRs,
  output logic [ADDR_W-1:0] exRt,
  output logic [ADDR_W-1:0] exDest,
  output logic [2:0]        exAluOp,
  output logic              exAluSrc,
  output logic              exRegWrite,
  output logic              exMemRead,
  output logic              exMemWrite,
  output logic              exMemToReg,
  output logic              exBranch
);

  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  ctrl_t             ctrl;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] imm;
  logic              legal;
  logic              reads_rt;
  logic              load_bubble;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;

  assign rs            = instrIn[25:21];
  assign rt            = instrIn[20:16];
  assign readRegister1 = rs;
  assign readRegister2 = rt;

  id_control_decoder #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_decoder (
    .instr   (instrIn),
    .ctrl    (ctrl),
    .dest    (dest),
    .imm     (imm),
    .legal   (legal),
    .reads_rt(reads_rt)
  );

  // A load in EX cannot forward in time; its consumer in ID must wait one cycle.
  assign stallOut = validIn & exValid & exMemRead & (exDest != '0) &
                    ((exDest == rs) | ((exDest == rt) & reads_rt));

  assign load_bubble = flush | stallOut | ~validIn | ~legal;

`ifdef WB_BYPASS_EN
  assign rs_data = (RegisterWrite && (writeRegister != '0) && (writeRegister == rs)) ? writeBack : readData1;
  assign rt_data = (RegisterWrite && (writeRegister != '0) && (writeRegister == rt)) ? writeBack : readData2;
`else
  logic unused_wb;
  assign unused_wb = &{1'b0, writeRegister, writeBack, RegisterWrite};
  assign rs_data   = readData1;
  assign rt_data   = readData2;
`endif

  always_ff @(posedge clk) begin
    if (rst || load_bubble) begin
      exValid    <= 1'b0;
      exPc       <= '0;
      exRsData   <= '0;
      exRtData   <= '0;
      exImm      <= '0;
      exRs       <= '0;
      exRt       <= '0;
      exDest     <= '0;
      exAluOp    <= '0;
      exAluSrc   <= 1'b0;
      exRegWrite <= 1'b0;
      exMemRead  <= 1'b0;
      exMemWrite <= 1'b0;
      exMemToReg <= 1'b0;
      exBranch   <= 1'b0;
    end else begin
      exValid    <= 1'b1;
      exPc       <= pcIn;
      exRsData   <= rs_data;
      exRtData   <= rt_data;
      exImm      <= imm;
      exRs       <= rs;
      exRt       <= rt;
      exDest     <= dest;
      exAluOp    <= ctrl.alu_op;
      exAluSrc   <= ctrl.alu_src;
      exRegWrite <= ctrl.reg_write;
      exMemRead  <= ctrl.mem_read;
      exMemWrite <= ctrl.mem_write;
      exMemToReg <= ctrl.mem_to_reg;
      exBranch   <= ctrl.branch;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed scoreboard bench for id_ex_stage: expected EX contents are queued
// when each instruction is driven and compared one edge later.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, validIn, flush, RegisterWrite;
  logic [31:0] instrIn, pcIn, readData1, readData2, writeBack;
  logic [4:0]  writeRegister;
  logic [4:0]  readRegister1, readRegister2;
  logic        stallOut, exValid;
  logic [31:0] exPc, exRsData, exRtData, exImm;
  logic [4:0]  exRs, exRt, exDest;
  logic [2:0]  exAluOp;
  logic        exAluSrc, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .validIn(validIn), .instrIn(instrIn), .pcIn(pcIn), .flush(flush),
    .readRegister1(readRegister1), .readRegister2(readRegister2),
    .readData1(readData1), .readData2(readData2),
    .writeRegister(writeRegister), .writeBack(writeBack), .RegisterWrite(RegisterWrite),
    .stallOut(stallOut), .exValid(exValid), .exPc(exPc), .exRsData(exRsData),
    .exRtData(exRtData), .exImm(exImm), .exRs(exRs), .exRt(exRt), .exDest(exDest),
    .exAluOp(exAluOp), .exAluSrc(exAluSrc), .exRegWrite(exRegWrite), .exMemRead(exMemRead),
    .exMemWrite(exMemWrite), .exMemToReg(exMemToReg), .exBranch(exBranch)
  );

  // ctl = {aluSrc, regWrite, memRead, memWrite, memToReg, branch}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, rsd, rtd, imm;
    logic [4:0]  rs, rt, dest;
    logic [2:0]  op;
    logic [5:0]  ctl;
  } ex_t;

  localparam ex_t BUB = '0;
  localparam logic [31:0] I_LW  = 32'h8C220000;  // LW  $2,0($1)
  localparam logic [31:0] I_USE = 32'h00452020;  // ADD $4,$2,$5

  ex_t sb[$];
  ex_t obs;
  int  vectors = 0;
  int  miscompares = 0;

  assign obs = {exValid, exPc, exRsData, exRtData, exImm, exRs, exRt, exDest, exAluOp,
                exAluSrc, exRegWrite, exMemRead, exMemWrite, exMemToReg, exBranch};

  function automatic logic [31:0] rfv(input logic [4:0] r);
    return (r == 5'd0) ? 32'h0 : (32'h1000_0000 | (r * 32'h11));
  endfunction

  function automatic ex_t mk(input logic [31:0] pc, input logic [31:0] instr, input logic [31:0] imm,
                             input logic [4:0] dest, input logic [2:0] op, input logic [5:0] ctl);
    ex_t e;
    e.valid = 1'b1;
    e.pc    = pc;
    e.rs    = instr[25:21];
    e.rt    = instr[20:16];
    e.rsd   = rfv(instr[25:21]);
    e.rtd   = rfv(instr[20:16]);
    e.imm   = imm;
    e.dest  = dest;
    e.op    = op;
    e.ctl   = ctl;
    return e;
  endfunction

  task automatic apply(input string tag, input logic r, input logic v, input logic f,
                       input logic [31:0] instr, input logic [31:0] pc,
                       input logic exp_stall, input ex_t e);
    ex_t x;
    rst       = r;
    validIn   = v;
    flush     = f;
    instrIn   = instr;
    pcIn      = pc;
    readData1 = rfv(instr[25:21]);
    readData2 = rfv(instr[20:16]);
    #1;
    vectors++;
    assert (stallOut === exp_stall) else begin
      miscompares++;
      $error("FAIL %s stall observed=%b expected=%b", tag, stallOut, exp_stall);
    end
    vectors++;
    assert ({readRegister1, readRegister2} === instr[25:16]) else begin
      miscompares++;
      $error("FAIL %s readreg observed=%h expected=%h", tag, {readRegister1, readRegister2}, instr[25:16]);
    end
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    vectors++;
    assert (obs === x) else begin
      miscompares++;
      $error("FAIL %s ex observed=%h expected=%h", tag, obs, x);
    end
    $display("step %-10s instr=%h stall=%b exValid=%b exDest=%0d", tag, instr, stallOut, exValid, exDest);
  endtask

  initial begin
    ex_t e;
    rst = 1'b1; validIn = 1'b0; flush = 1'b0; instrIn = '0; pcIn = '0;
    readData1 = '0; readData2 = '0; writeRegister = '0; writeBack = '0; RegisterWrite = 1'b0;
    @(posedge clk);
    #1;
    apply("reset", 1, 0, 0, 32'h0, 32'h0, 0, BUB);

    apply("addi", 0, 1, 0, 32'h2003FFFB, 32'h104, 0, mk(32'h104, 32'h2003FFFB, 32'hFFFFFFFB, 5'd3, 3'd0, 6'b110000));

    // load-use on rs: one stall, one bubble, then the ADD issues
    apply("lw", 0, 1, 0, I_LW, 32'h108, 0, mk(32'h108, I_LW, 32'h0, 5'd2, 3'd0, 6'b111010));
    apply("use_stall", 0, 1, 0, I_USE, 32'h10C, 1, BUB);
    apply("use_issue", 0, 1, 0, I_USE, 32'h10C, 0, mk(32'h10C, I_USE, 32'h2020, 5'd4, 3'd0, 6'b010000));

    apply("lw", 0, 1, 0, I_LW, 32'h108, 0, mk(32'h108, I_LW, 32'h0, 5'd2, 3'd0, 6'b111010));
    apply("indep", 0, 1, 0, 32'h00C72020, 32'h110, 0, mk(32'h110, 32'h00C72020, 32'h2020, 5'd4, 3'd0, 6'b010000));
    apply("lw", 0, 1, 0, I_LW, 32'h108, 0, mk(32'h108, I_LW, 32'h0, 5'd2, 3'd0, 6'b111010));
    apply("sw_stall", 0, 1, 0, 32'hAC220004, 32'h114, 1, BUB);
    apply("sw", 0, 1, 0, 32'hAC220004, 32'h114, 0, mk(32'h114, 32'hAC220004, 32'h4, 5'd2, 3'd0, 6'b100100));
    apply("lw", 0, 1, 0, I_LW, 32'h108, 0, mk(32'h108, I_LW, 32'h0, 5'd2, 3'd0, 6'b111010));
    apply("addi_rt", 0, 1, 0, 32'h20620001, 32'h118, 0, mk(32'h118, 32'h20620001, 32'h1, 5'd2, 3'd0, 6'b110000));
    apply("lw_r0", 0, 1, 0, 32'h8C200000, 32'h11C, 0, mk(32'h11C, 32'h8C200000, 32'h0, 5'd0, 3'd0, 6'b101010));
    apply("use_r0", 0, 1, 0, 32'h00002020, 32'h120, 0, mk(32'h120, 32'h00002020, 32'h2020, 5'd4, 3'd0, 6'b010000));

    // flush alone, and flush coinciding with a stall
    apply("flush", 0, 1, 1, I_USE, 32'h124, 0, BUB);
    apply("lw", 0, 1, 0, I_LW, 32'h108, 0, mk(32'h108, I_LW, 32'h0, 5'd2, 3'd0, 6'b111010));
    apply("flush_stl", 0, 1, 1, I_USE, 32'h10C, 1, BUB);
    apply("after_fl", 0, 1, 0, I_USE, 32'h10C, 0, mk(32'h10C, I_USE, 32'h2020, 5'd4, 3'd0, 6'b010000));

    apply("andi", 0, 1, 0, 32'h30258000, 32'h128, 0, mk(32'h128, 32'h30258000, 32'h00008000, 5'd5, 3'd2, 6'b110000));
    apply("ori", 0, 1, 0, 32'h3425FFFF, 32'h12C, 0, mk(32'h12C, 32'h3425FFFF, 32'h0000FFFF, 5'd5, 3'd3, 6'b110000));
    apply("lui", 0, 1, 0, 32'h3C068001, 32'h130, 0, mk(32'h130, 32'h3C068001, 32'hFFFF8001, 5'd6, 3'd5, 6'b110000));
    apply("beq", 0, 1, 0, 32'h1022FFFF, 32'h134, 0, mk(32'h134, 32'h1022FFFF, 32'hFFFFFFFF, 5'd2, 3'd1, 6'b000001));
    apply("slt", 0, 1, 0, 32'h0022382A, 32'h138, 0, mk(32'h138, 32'h0022382A, 32'h0000382A, 5'd7, 3'd4, 6'b010000));
    apply("sub", 0, 1, 0, 32'h00223822, 32'h138, 0, mk(32'h138, 32'h00223822, 32'h00003822, 5'd7, 3'd1, 6'b010000));
    apply("and", 0, 1, 0, 32'h00223824, 32'h138, 0, mk(32'h138, 32'h00223824, 32'h00003824, 5'd7, 3'd2, 6'b010000));
    apply("or", 0, 1, 0, 32'h00223825, 32'h138, 0, mk(32'h138, 32'h00223825, 32'h00003825, 5'd7, 3'd3, 6'b010000));
    apply("add_r0", 0, 1, 0, 32'h00220020, 32'h13C, 0, mk(32'h13C, 32'h00220020, 32'h00000020, 5'd0, 3'd0, 6'b000000));
    apply("bad_op", 0, 1, 0, 32'hFC000000, 32'h13C, 0, BUB);
    apply("bad_fn", 0, 1, 0, 32'h0000003F, 32'h13C, 0, BUB);
    apply("lw", 0, 1, 0, I_LW, 32'h108, 0, mk(32'h108, I_LW, 32'h0, 5'd2, 3'd0, 6'b111010));
    apply("invalid", 0, 0, 0, I_USE, 32'h10C, 0, BUB);

    // WB write port on the same cycle as the ID read
    RegisterWrite = 1'b1; writeRegister = 5'd5; writeBack = 32'hDEADBEEF;
    e = mk(32'h140, 32'h00A62020, 32'h2020, 5'd4, 3'd0, 6'b010000);
`ifdef WB_BYPASS_EN
    e.rsd = 32'hDEADBEEF;
`endif
    apply("byp_rs", 0, 1, 0, 32'h00A62020, 32'h140, 0, e);
    writeRegister = 5'd6;
    e = mk(32'h140, 32'h00A62020, 32'h2020, 5'd4, 3'd0, 6'b010000);
`ifdef WB_BYPASS_EN
    e.rtd = 32'hDEADBEEF;
`endif
    apply("byp_rt", 0, 1, 0, 32'h00A62020, 32'h140, 0, e);
    writeRegister = 5'd0;
    apply("byp_r0", 0, 1, 0, 32'h00062020, 32'h144, 0, mk(32'h144, 32'h00062020, 32'h2020, 5'd4, 3'd0, 6'b010000));
    RegisterWrite = 1'b0; writeRegister = 5'd5;
    apply("byp_off", 0, 1, 0, 32'h00A62020, 32'h148, 0, mk(32'h148, 32'h00A62020, 32'h2020, 5'd4, 3'd0, 6'b010000));
    writeRegister = 5'd0; writeBack = '0;

    // reset with a load in EX and its consumer in ID
    apply("lw", 0, 1, 0, I_LW, 32'h108, 0, mk(32'h108, I_LW, 32'h0, 5'd2, 3'd0, 6'b111010));
    apply("rst_mid", 1, 1, 0, I_USE, 32'h10C, 1, BUB);
    apply("post_rst", 0, 1, 0, I_USE, 32'h10C, 0, mk(32'h10C, I_USE, 32'h2020, 5'd4, 3'd0, 6'b010000));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
